sprite_pixel_scheduler: RTL and testbench

Per-pixel controller that shares one synchronous sprite ROM port between NUM_SPRITES overlapping sprites (tanks, bullets, overlays). On each pixel strobe from the VGA timing path it snapshots which sprites cover the pixel. It then queries their ROM addresses one at a time in priority order and commits the first non-transparent 4-bit palette index to the palette lookup stage. If no sprite wins, it flags background so the colour mapper draws the backdrop.

---
 rtl/sprite_pixel_scheduler_pkg.sv | 22 ++
 rtl/sprite_pixel_scheduler_if.sv | 37 +++
 rtl/sprite_pixel_scheduler_prio_enc.sv | 26 ++
 rtl/sprite_pixel_scheduler.sv | 110 +++++++++++
 tb/tb_sprite_pixel_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pixel_scheduler_pkg.sv
// Shared types and constants for the sprite pixel scheduler and the
// sprite priority encoder it uses.
package sprite_sched_pkg;

  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_ADDR_W      = 12;
  localparam int IDX_W           = 4;
  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } sched_state_e;

  // Index width for a sprite number; never zero so a single sprite still has a bit.
  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_pixel_scheduler_if.sv
// Bundle of pixel-request, ROM and result signals between the VGA path,
// the sprite ROM and the scheduler.
interface sprite_pixel_scheduler_if
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int ADDR_W      = DEF_ADDR_W
);
  localparam int LAYER_W = layer_w(NUM_SPRITES);

  // pix_en is a one-cycle strobe with no ready: the scheduler accepts it only
  // when idle, otherwise it is dropped and flagged on overrun. The ROM has no
  // handshake: rom_index is valid exactly one clock after rom_addr. pix_valid
  // is a one-cycle pulse marking the cycle in which pix_* change.
  logic                          pix_en;
  logic [NUM_SPRITES-1:0]        hit;
  logic [NUM_SPRITES*ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0]             rom_addr;
  logic [IDX_W-1:0]              rom_index;
  logic [IDX_W-1:0]              pix_index;
  logic                          pix_opaque;
  logic [LAYER_W-1:0]            pix_layer;
  logic                          pix_valid;
  logic                          busy;
  logic                          overrun;

  modport slave (
    input  pix_en, hit, addr_in, rom_index,
    output rom_addr, pix_index, pix_opaque, pix_layer, pix_valid, busy, overrun
  );

  modport master (
    output pix_en, hit, addr_in, rom_index,
    input  rom_addr, pix_index, pix_opaque, pix_layer, pix_valid, busy, overrun
  );

endinterface

// File: rtl/sprite_pixel_scheduler_prio_enc.sv
// Combinational lowest-set-bit finder: bit 0 has the highest priority.
// Also used by the bullet collision arbiter.
module sprite_prio_enc
  import sprite_sched_pkg::*;
#(
  parameter int N  = DEF_NUM_SPRITES,
  parameter int IW = layer_w(N)
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_pixel_scheduler.sv
// Shares one synchronous sprite ROM port between overlapping sprites and
// commits the highest-priority opaque palette index for each pixel.
module sprite_pixel_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  sprite_pixel_scheduler_if.slave  bus,
  output sched_state_e             dbg_state_o
);

  localparam int LAYER_W = layer_w(NUM_SPRITES);

  sched_state_e           state_q;
  logic [NUM_SPRITES-1:0] pending_q;
  logic [ADDR_W-1:0]      addr_q [NUM_SPRITES];
  logic [LAYER_W-1:0]     sel_q;
  logic [ADDR_W-1:0]      rom_addr_q;
  logic [IDX_W-1:0]       pix_index_q;
  logic                   pix_opaque_q;
  logic [LAYER_W-1:0]     pix_layer_q;
  logic                   pix_valid_q;
  logic                   overrun_q;

  logic [LAYER_W-1:0]     sel_d;
  logic                   any_d;

  sprite_prio_enc #(
    .N  (NUM_SPRITES),
    .IW (LAYER_W)
  ) u_prio_enc (
    .mask_i (pending_q),
    .idx_o  (sel_d),
    .any_o  (any_d)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      sel_q        <= '0;
      rom_addr_q   <= '0;
      pix_index_q  <= '0;
      pix_opaque_q <= 1'b0;
      pix_layer_q  <= '0;
      pix_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      pix_valid_q <= 1'b0;
      // A strobe on the commit edge still sees a non-idle state and is dropped.
      overrun_q   <= bus.pix_en && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.pix_en) begin
            pending_q <= bus.hit;
            for (int i = 0; i < NUM_SPRITES; i++) begin
              addr_q[i] <= bus.addr_in[i*ADDR_W +: ADDR_W];
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!any_d) begin
            pix_index_q  <= TRANSPARENT_IDX;
            pix_opaque_q <= 1'b0;
            pix_layer_q  <= '0;
            pix_valid_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            rom_addr_q <= addr_q[sel_d];
            sel_q      <= sel_d;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          state_q <= CHECK;
        end
        CHECK: begin
          if (bus.rom_index != TRANSPARENT_IDX) begin
            pix_index_q  <= bus.rom_index;
            pix_opaque_q <= 1'b1;
            pix_layer_q  <= sel_q;
            pix_valid_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            pending_q[sel_q] <= 1'b0;
            state_q          <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.pix_index  = pix_index_q;
  assign bus.pix_opaque = pix_opaque_q;
  assign bus.pix_layer  = pix_layer_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// Directed and randomized bench for sprite_pixel_scheduler with a synchronous
// ROM model and a priority-scan reference model.
module tb_sprite_pixel_scheduler;
  import sprite_sched_pkg::*;

  localparam int NS = 4;
  localparam int AW = 12;

  logic         clk;
  logic         rst;
  sched_state_e dbg_state;

  int errors;
  int checks;

  logic [3:0] rom_mem [4096];

  logic [3:0] held_idx;
  logic       held_op;
  logic [1:0] held_lay;

  sprite_pixel_scheduler_if #(.NUM_SPRITES(NS), .ADDR_W(AW)) bus_if ();

  sprite_pixel_scheduler #(.NUM_SPRITES(NS), .ADDR_W(AW)) dut (
    .Clk         (clk),
    .Reset       (rst),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous sprite ROM: data one clock after address
  always @(posedge clk) bus_if.rom_index <= rom_mem[bus_if.rom_addr];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_index"},  48'(bus_if.pix_index), 48'(0));
    check({tag, "_pix_opaque"}, 48'(bus_if.pix_opaque), 48'(0));
    check({tag, "_pix_layer"},  48'(bus_if.pix_layer), 48'(0));
    check({tag, "_pix_valid"},  48'(bus_if.pix_valid), 48'(0));
    check({tag, "_busy"},       48'(bus_if.busy), 48'(0));
    check({tag, "_overrun"},    48'(bus_if.overrun), 48'(0));
    check({tag, "_rom_addr"},   48'(bus_if.rom_addr), 48'(0));
    check({tag, "_state"},      48'(dbg_state), 48'(IDLE));
  endtask

  function automatic logic [47:0] rand_addrs();
    logic [47:0] a;
    a = {16'($urandom), 32'($urandom)};
    return a;
  endfunction

  // One pixel: drive pix_en right after an edge, then walk the cycles.
  // Reference: scan set hit bits from sprite 0 upward; each ROM read costs
  // 3 clocks; an opaque hit commits 1 clock after its read's check, an
  // all-transparent search needs one more ISSUE clock to commit background.
  task automatic run_pixel(input logic [3:0] h, input logic [47:0] a, input bit ov_req);
    logic [11:0] reads [$];
    int          win;
    int          lat;
    bit          ov;
    logic [3:0]  e_idx;
    logic        e_op;
    logic [1:0]  e_lay;
    win = -1;
    e_idx = 4'h0;
    for (int i = 0; i < NS; i++) begin
      if (h[i] && win < 0) begin
        reads.push_back(a[i*AW +: AW]);
        if (rom_mem[a[i*AW +: AW]] != 4'h0) begin
          win   = i;
          e_idx = rom_mem[a[i*AW +: AW]];
        end
      end
    end
    if (win >= 0) begin
      lat   = 1 + 3 * reads.size();
      e_op  = 1'b1;
      e_lay = 2'(win);
    end else begin
      lat   = 2 + 3 * reads.size();
      e_idx = 4'h0;
      e_op  = 1'b0;
      e_lay = 2'd0;
    end
    ov = ov_req && (reads.size() > 0);

    bus_if.pix_en  = 1'b1;
    bus_if.hit     = h;
    bus_if.addr_in = a;
    for (int n = 1; n <= lat + 1; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bus_if.pix_en  = 1'b0;
        bus_if.hit     = 4'($urandom);
        bus_if.addr_in = rand_addrs();
      end
      if (n == lat) begin
        held_idx = e_idx;
        held_op  = e_op;
        held_lay = e_lay;
      end
      check("pix_valid",  48'(bus_if.pix_valid), 48'(n == lat));
      check("busy",       48'(bus_if.busy), 48'(n < lat));
      check("overrun",    48'(bus_if.overrun), 48'(ov && n == 4));
      check("pix_index",  48'(bus_if.pix_index), 48'(held_idx));
      check("pix_opaque", 48'(bus_if.pix_opaque), 48'(held_op));
      check("pix_layer",  48'(bus_if.pix_layer), 48'(held_lay));
      for (int j = 0; j < reads.size(); j++) begin
        if (n == 2 + 3 * j) check("rom_addr_issue", 48'(bus_if.rom_addr), 48'(reads[j]));
      end
      if (n == lat + 1 && reads.size() > 0)
        check("rom_addr_hold", 48'(bus_if.rom_addr), 48'(reads[reads.size()-1]));
      if (ov && n == 3) begin
        bus_if.pix_en  = 1'b1;
        bus_if.hit     = 4'hF;
        bus_if.addr_in = rand_addrs();
      end
      if (n == 4) bus_if.pix_en = 1'b0;
    end
  endtask

  initial begin
    logic [47:0] addr_a;
    logic [47:0] addr_b;
    errors   = 0;
    checks   = 0;
    held_idx = 4'h0;
    held_op  = 1'b0;
    held_lay = 2'd0;
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    addr_a = {12'h444, 12'h333, 12'h222, 12'h111};
    addr_b = {12'h555, 12'h666, 12'h777, 12'h888};
    rom_mem[12'h111] = 4'h0;
    rom_mem[12'h222] = 4'h9;
    rom_mem[12'h333] = 4'h5;
    rom_mem[12'h444] = 4'h0;
    rom_mem[12'h555] = 4'h0;
    rom_mem[12'h666] = 4'h0;
    rom_mem[12'h777] = 4'h0;
    rom_mem[12'h888] = 4'h0;

    rst            = 1'b1;
    bus_if.pix_en  = 1'b0;
    bus_if.hit     = 4'h0;
    bus_if.addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // directed scenarios
    run_pixel(4'b0000, addr_a, 1'b0);
    run_pixel(4'b0100, addr_a, 1'b0);
    run_pixel(4'b0011, addr_a, 1'b0);
    run_pixel(4'b1111, addr_b, 1'b0);
    run_pixel(4'b0100, addr_a, 1'b1);
    run_pixel(4'b1010, addr_a, 1'b1);

    // reset mid-search
    bus_if.pix_en  = 1'b1;
    bus_if.hit     = 4'b0100;
    bus_if.addr_in = addr_a;
    @(posedge clk);
    #1;
    bus_if.pix_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    held_idx = 4'h0;
    held_op  = 1'b0;
    held_lay = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("post_reset_valid", 48'(bus_if.pix_valid), 48'(0));
    end
    run_pixel(4'b0100, addr_a, 1'b0);

    // randomized pixels, some with a colliding strobe
    for (int k = 0; k < 40; k++) begin
      run_pixel(4'($urandom), rand_addrs(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        check("idle_gap_valid", 48'(bus_if.pix_valid), 48'(0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
